// File: rtl/mainbus_pkg.sv
// mainbus_pkg: shared constants, state type and rotation helper for the main bus arbiter
package mainbus_pkg;
  localparam int SRC_ALU = 0;
  localparam int SRC_REG = 1;
  localparam int SRC_MEM = 2;
  localparam int NUM_SRC = 3;
  localparam int BUS_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, GRANT, TURN} arb_state_t;
  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s == 2'(SRC_MEM)) ? 2'd0 : s + 2'd1;
  endfunction
endpackage

// File: rtl/mainbus_arbiter_if.sv
// mainbus_arbiter_if: main bus request/grant/data bundle
//   req[2:0] (alu, register_bank, memory), bus_in: from core control / bus mux
//   gnt_*, bus_q, bus_q_valid, busy: from the arbiter
//   modport master = arbiter side, slave = requester / mux side
interface mainbus_arbiter_if import mainbus_pkg::*; #(parameter int WIDTH = BUS_WIDTH);
  logic [NUM_SRC-1:0] req;
  logic [WIDTH-1:0] bus_in;
  logic gnt_alu;
  logic gnt_register_bank;
  logic gnt_memory;
  logic [WIDTH-1:0] bus_q;
  logic bus_q_valid;
  logic busy;
  modport master (input req, bus_in, output gnt_alu, gnt_register_bank, gnt_memory, bus_q, bus_q_valid, busy);
  modport slave (output req, bus_in, input gnt_alu, gnt_register_bank, gnt_memory, bus_q, bus_q_valid, busy);
endinterface

// File: rtl/mainbus_rr_pick.sv
// mainbus_rr_pick: round-robin winner search starting at rr_ptr_i, wrapping mod 3
//   req_i[2:0], rr_ptr_i[1:0] -> win_o[1:0] (valid when any_req_o), any_req_o
module mainbus_rr_pick import mainbus_pkg::*; (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [1:0]         rr_ptr_i,
  output logic [1:0]         win_o,
  output logic               any_req_o
);
  logic [1:0] p1, p2;
  assign p1 = next_src(rr_ptr_i);
  assign p2 = next_src(p1);
  assign win_o = req_i[rr_ptr_i] ? rr_ptr_i : req_i[p1] ? p1 : p2;
  assign any_req_o = |req_i;
endmodule

// File: rtl/mainbus_arbiter.sv
// mainbus_arbiter: round-robin main bus arbiter with hold limit, turnaround cycle and bus capture
//   clk, rst_n (sync, active low); bus: mainbus_arbiter_if.master
//   MAINBUS_ARB_STATS_EN adds gnt_cnt_alu/register_bank/memory (16b saturating tenure counters)
module mainbus_arbiter import mainbus_pkg::*; #(
  parameter int WIDTH = BUS_WIDTH,
  parameter int MAX_HOLD = 8
) (
  input logic clk,
  input logic rst_n,
  mainbus_arbiter_if.master bus
`ifdef MAINBUS_ARB_STATS_EN
  ,
  output logic [15:0] gnt_cnt_alu,
  output logic [15:0] gnt_cnt_register_bank,
  output logic [15:0] gnt_cnt_memory
`endif
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  arb_state_t state_q;
  logic [1:0] owner_q, rr_ptr_q, win;
  logic any_req;
  logic [HW-1:0] hold_cnt_q;
  logic [NUM_SRC-1:0] gnt_q;
  logic [WIDTH-1:0] bus_q_q;
  logic valid_q;
  mainbus_rr_pick u_pick (.req_i(bus.req), .rr_ptr_i(rr_ptr_q), .win_o(win), .any_req_o(any_req));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_ptr_q <= '0;
      hold_cnt_q <= '0;
      gnt_q <= '0;
      bus_q_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= state_q == GRANT;
      if (state_q == GRANT) bus_q_q <= bus.bus_in;
      case (state_q)
        IDLE: if (any_req) begin
          state_q <= GRANT;
          owner_q <= win;
          gnt_q <= NUM_SRC'(1) << win;
          hold_cnt_q <= HW'(1);
        end
        GRANT: if (bus.req[owner_q] && hold_cnt_q != HW'(MAX_HOLD)) hold_cnt_q <= hold_cnt_q + 1'b1;
        else begin
          // moving the pointer past the owner makes a forced-release owner last in line
          state_q <= TURN;
          gnt_q <= '0;
          rr_ptr_q <= next_src(owner_q);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.gnt_alu = gnt_q[SRC_ALU];
  assign bus.gnt_register_bank = gnt_q[SRC_REG];
  assign bus.gnt_memory = gnt_q[SRC_MEM];
  assign bus.bus_q = bus_q_q;
  assign bus.bus_q_valid = valid_q;
  assign bus.busy = state_q != IDLE;
`ifdef MAINBUS_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_SRC];
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '{default: '0};
    else if (state_q == IDLE && any_req && cnt_q[win] != 16'hFFFF) cnt_q[win] <= cnt_q[win] + 16'd1;
  end
  assign gnt_cnt_alu = cnt_q[SRC_ALU];
  assign gnt_cnt_register_bank = cnt_q[SRC_REG];
  assign gnt_cnt_memory = cnt_q[SRC_MEM];
`endif
endmodule

// File: tb/tb_mainbus_arbiter.sv
// tb_mainbus_arbiter: directed + random checks of two arbiters (MAX_HOLD 8 and 2) against a tenure-level model
module tb_mainbus_arbiter;
  import mainbus_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [2:0] req;
  logic [31:0] bus_in;
  int n_chk = 0;
  int n_err = 0;
  mainbus_arbiter_if #(.WIDTH(32)) if8 (), if2 ();
  assign if8.req = req;
  assign if8.bus_in = bus_in;
  assign if2.req = req;
  assign if2.bus_in = bus_in;
`ifdef MAINBUS_ARB_STATS_EN
  logic [15:0] c8 [3];
  logic [15:0] c2 [3];
`endif
  mainbus_arbiter #(.WIDTH(32), .MAX_HOLD(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8.master)
`ifdef MAINBUS_ARB_STATS_EN
    , .gnt_cnt_alu(c8[0]), .gnt_cnt_register_bank(c8[1]), .gnt_cnt_memory(c8[2])
`endif
  );
  mainbus_arbiter #(.WIDTH(32), .MAX_HOLD(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.master)
`ifdef MAINBUS_ARB_STATS_EN
    , .gnt_cnt_alu(c2[0]), .gnt_cnt_register_bank(c2[1]), .gnt_cnt_memory(c2[2])
`endif
  );
  // model: phase 0=idle 1=owned 2=turnaround; k=0 is MAX_HOLD 8, k=1 is MAX_HOLD 2
  int m_phase [2];
  int m_owner [2];
  int m_cnt [2];
  int m_ptr [2];
  int m_stat [2][3];
  logic [31:0] m_bq [2];
  logic m_bv [2];
  int mh [2] = '{8, 2};
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask
  task automatic model_step(input int k);
    if (!rst_n) begin
      m_phase[k] = 0; m_owner[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0;
      m_bq[k] = '0; m_bv[k] = 1'b0;
      for (int j = 0; j < 3; j++) m_stat[k][j] = 0;
    end else begin
      m_bv[k] = (m_phase[k] == 1);
      if (m_bv[k]) m_bq[k] = bus_in;
      if (m_phase[k] == 0) begin
        if (req != 0) begin
          for (int i = 2; i >= 0; i--) if (req[(m_ptr[k] + i) % 3]) m_owner[k] = (m_ptr[k] + i) % 3;
          m_phase[k] = 1;
          m_cnt[k] = 1;
          if (m_stat[k][m_owner[k]] < 65535) m_stat[k][m_owner[k]]++;
        end
      end else if (m_phase[k] == 1) begin
        if (req[m_owner[k]] && m_cnt[k] < mh[k]) m_cnt[k]++;
        else begin
          m_phase[k] = 2;
          m_ptr[k] = (m_owner[k] + 1) % 3;
        end
      end else m_phase[k] = 0;
    end
  endtask
  function automatic logic [2:0] exp_gnt(input int k);
    return (m_phase[k] == 1) ? 3'(1 << m_owner[k]) : 3'b000;
  endfunction
  function automatic logic [2:0] g8();
    return {if8.gnt_memory, if8.gnt_register_bank, if8.gnt_alu};
  endfunction
  function automatic logic [2:0] g2();
    return {if2.gnt_memory, if2.gnt_register_bank, if2.gnt_alu};
  endfunction
  task automatic compare_all();
    check("gnt8", g8(), exp_gnt(0));
    check("busy8", if8.busy, m_phase[0] != 0);
    check("valid8", if8.bus_q_valid, m_bv[0]);
    check("busq8", if8.bus_q, m_bq[0]);
    check("gnt2", g2(), exp_gnt(1));
    check("busy2", if2.busy, m_phase[1] != 0);
    check("valid2", if2.bus_q_valid, m_bv[1]);
    check("busq2", if2.bus_q, m_bq[1]);
`ifdef MAINBUS_ARB_STATS_EN
    for (int j = 0; j < 3; j++) begin
      check("stat8", c8[j], m_stat[0][j]);
      check("stat2", c2[j], m_stat[1][j]);
    end
`endif
  endtask
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  initial begin
    int ng, nv;
    logic [2:0] prev, cur;
    logic [2:0] order [$];
    rst_n = 1'b0;
    req = 3'b111;
    bus_in = '0;
    repeat (3) tick();
    check("t1_gnt", g8(), 3'b000);
    check("t1_busq", if8.bus_q, 32'h0);
    check("t1_busy", if8.busy, 1'b0);
    rst_n = 1'b1;
    tick();
    check("t1_gnt_alu", if8.gnt_alu, 1'b1);
    do_reset();
    req = 3'b100;
    bus_in = 32'hDEADBEEF;
    ng = 0; nv = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) req = 3'b000;
      tick();
      ng += int'(if8.gnt_memory);
      nv += int'(if8.bus_q_valid);
    end
    check("t2_gnt_cycles", ng, 3);
    check("t2_valid_cycles", nv, 3);
    check("t2_busq", if8.bus_q, 32'hDEADBEEF);
    do_reset();
    req = 3'b111;
    prev = 3'b000;
    for (int i = 0; i < 16; i++) begin
      tick();
      cur = g2();
      if (cur != 0 && prev == 0) order.push_back(cur);
      prev = cur;
    end
    check("t3_tenures", order.size() >= 4, 1'b1);
    check("t3_first", order.size() > 0 ? order[0] : 3'b000, 3'b001);
    check("t3_second", order.size() > 1 ? order[1] : 3'b000, 3'b010);
    check("t3_third", order.size() > 2 ? order[2] : 3'b000, 3'b100);
    check("t3_fourth", order.size() > 3 ? order[3] : 3'b000, 3'b001);
    do_reset();
    req = 3'b001;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t4_hold", if8.gnt_alu, (i % 10) < 8);
    end
    req = 3'b000;
    do_reset();
    req = 3'b010;
    ng = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      req = 3'b000;
      ng += int'(if8.gnt_register_bank);
    end
    check("t5_min_tenure", ng, 1);
    do_reset();
    req = 3'b001;
    tick();
    req = 3'b000;
    repeat (2) tick();
    req = 3'b111;
    repeat (3) tick();
    check("t6_owner", g8(), 3'b010);
    rst_n = 1'b0;
    tick();
    check("t6_gnt_drop", g8(), 3'b000);
    check("t6_busy", if8.busy, 1'b0);
`ifdef MAINBUS_ARB_STATS_EN
    check("t6_cnt_alu", c8[0], 16'd0);
    check("t6_cnt_reg", c8[1], 16'd0);
`endif
    rst_n = 1'b1;
    tick();
    check("t6_alu_first", g8(), 3'b001);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
      bus_in = $urandom;
      rst_n = ($urandom_range(0, 59) != 0);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
